// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: bus-visible TXDATA/STATUS/DIV registers,
// a small circular byte FIFO and an 8N1 serializer with programmable bit time.
module mmio_uart_tx #(
    parameter int unsigned CLK_DIV_RESET = 117,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re,
    input  logic [3:0]  wstrb,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        tx,
    output logic [1:0]  state_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e          state_q, state_d;
    logic [15:0]     baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [15:0]     div_q, div_d;
    logic            ovf_q, ovf_d;
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [31:0]     rd_q, rdata;

    logic       wr_en, push_req, push, pop, full, empty, busy;
    logic [1:0] sel;
    logic       unused_bits;

    assign sel      = a[3:2];
    assign wr_en    = !rst && (|wstrb);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign busy     = (state_q != S_IDLE);
    assign push_req = wr_en && (sel == 2'd0) && wstrb[0];
    // Fullness is judged before any same-cycle pop, so a full FIFO always drops.
    assign push     = push_req && !full;

    assign unused_bits = &{1'b0, a[31:4], a[1:0], wstrb[3:2], wd[31:16]};

    always_comb begin
        ovf_d = ovf_q;
        if (push_req && full) begin
            ovf_d = 1'b1;
        end else if (wr_en && (sel == 2'd1) && wstrb[1] && wd[8]) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        div_d = div_q;
        if (wr_en && (sel == 2'd2)) begin
            if (wstrb[0]) div_d[7:0]  = wd[7:0];
            if (wstrb[1]) div_d[15:8] = wd[15:8];
            if (div_d == 16'd0) div_d = 16'd1;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Transmit FSM; every bit start reloads the baud counter from the current DIV.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    baud_d  = div_q - 16'd1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == 16'd0) begin
                    bit_d   = 3'd0;
                    baud_d  = div_q - 16'd1;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d = div_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_STOP: begin
                if (baud_q == 16'd0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        baud_d  = div_q - 16'd1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rdata = 32'd0;
        case (sel)
            2'd1:    rdata = {23'd0, ovf_q, 4'(count_q), 1'b0, empty, full, busy};
            2'd2:    rdata = {16'd0, div_q};
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            div_q   <= 16'(CLK_DIV_RESET);
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (re)   rd_q   <= rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wd[7:0];
    end

    assign rd      = rd_q;
    assign tx      = tx_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: bus driver tasks, a UART receiver monitor and a
// read-data monitor that both pop expected values from scoreboard queues.
module tb_mmio_uart_tx;
  localparam int DEPTH   = 4;
  localparam int DIV_RST = 117;

  logic        clk = 1'b0;
  logic        rst, re, tx;
  logic [3:0]  wstrb;
  logic [31:0] a, wd, rd;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_done = 0;
  int model_div;
  bit model_ovf;
  bit mon_en;

  logic [7:0]  exp_q[$];
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  int          start_q[$];

  mmio_uart_tx #(.CLK_DIV_RESET(DIV_RST), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .re(re), .wstrb(wstrb), .a(a), .wd(wd),
    .rd(rd), .tx(tx), .state_o(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] status_word(input bit busy, input int cnt, input bit ovf);
    logic [31:0] w;
    w = 32'd0;
    w[0]   = busy;
    w[1]   = (cnt == DEPTH);
    w[2]   = (cnt == 0);
    w[7:4] = 4'(cnt);
    w[8]   = ovf;
    return w;
  endfunction

  // driver tasks: all are entered and left at a negedge
  task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
    logic [15:0] nd;
    a = {28'd0, r, 2'b00};
    wd = d;
    wstrb = s;
    if (r == 2'd2) begin
      nd = model_div[15:0];
      if (s[0]) nd[7:0] = d[7:0];
      if (s[1]) nd[15:8] = d[15:8];
      model_div = (nd == 16'd0) ? 1 : int'(nd);
    end
    if (r == 2'd1 && s[1] && d[8]) model_ovf = 1'b0;
    @(negedge clk);
    wstrb = 4'd0;
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    if (accepted) exp_q.push_back(b);
    else model_ovf = 1'b1;
    wr(2'd0, {24'd0, b}, 4'b0001);
  endtask

  task automatic rd_reg(input logic [1:0] r, input logic [31:0] expv, input string nm);
    a = {28'd0, r, 2'b00};
    re = 1'b1;
    rd_exp_q.push_back(expv);
    rd_name_q.push_back(nm);
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_wait", 32'(frames_done >= target), 32'd1);
  endtask

  // read-data monitor
  initial begin : rd_mon
    logic sampled;
    forever begin
      @(posedge clk);
      sampled = re && !rst;
      @(negedge clk);
      if (sampled) begin
        if (rd_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got 0x%0h expected no read", rd);
        end else begin
          check(rd_name_q.pop_front(), rd, rd_exp_q.pop_front());
        end
      end
    end
  end

  // UART receiver monitor: samples every cycle of every bit
  initial begin : tx_mon
    int st, dv;
    logic [9:0] bits;
    bit shape_ok;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx === 1'b0) begin
        st = cyc;
        dv = model_div;
        shape_ok = 1'b1;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < dv; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (c == 0) bits[b] = tx;
            else if (tx !== bits[b]) shape_ok = 1'b0;
          end
        end
        start_q.push_back(st);
        checks++;
        if (!shape_ok || bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
          errors++;
          $display("FAIL frame_shape: got bits 0b%b timing_ok=%0d expected start 0 stop 1 timing_ok=1",
                   bits, shape_ok);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got byte 0x%0h expected no frame", bits[8:1]);
        end else begin
          check("frame_data", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
        end
        frames_done++;
      end
    end
  end

  initial begin : stim
    int n, lows, base, dv, s1, s2;
    rst = 1'b1; re = 1'b0; wstrb = 4'd0; a = 32'd0; wd = 32'd0;
    mon_en = 1'b1; model_div = DIV_RST; model_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_rd", rd, 32'd0);
    rst = 1'b0;

    // register access and read latency
    rd_reg(2'd1, status_word(0, 0, 0), "status_reset");
    rd_reg(2'd2, 32'd117, "div_reset");
    idle(1);
    check("rd_hold", rd, 32'd117);
    rd_reg(2'd0, 32'd0, "txdata_reads_zero");
    rd_reg(2'd3, 32'd0, "reserved_reads_zero");
    wr(2'd3, 32'hFFFF_FFFF, 4'hF);
    rd_reg(2'd2, 32'(model_div), "reserved_write_ignored");
    wr(2'd2, 32'h0000_1234, 4'b0010);
    rd_reg(2'd2, 32'h0000_1275, "div_byte_strobe");
    wr(2'd2, 32'd0, 4'b0011);
    rd_reg(2'd2, 32'd1, "div_zero_stored_as_one");

    // single byte at DIV=4
    wr(2'd2, 32'd4, 4'b0011);
    start_q.delete();
    push(8'h55, 1'b1);
    wait_frames(1, 100);
    idle(3);
    rd_reg(2'd1, 32'h0000_0004, "status_after_single");

    // back-to-back frames at DIV=2, busy throughout
    wr(2'd2, 32'd2, 4'b0011);
    start_q.delete();
    base = frames_done;
    push(8'hA5, 1'b1);
    push(8'h3C, 1'b1);
    rd_reg(2'd1, status_word(1, 1, 0), "status_b2b");
    lows = 0;
    for (int i = 0; i < 38; i++) begin
      @(negedge clk);
      if (state_dbg == 2'd0) lows++;
    end
    check("b2b_busy_throughout", 32'(lows), 32'd0);
    wait_frames(base + 2, 60);
    if (start_q.size() >= 2) begin
      s1 = start_q.pop_front();
      s2 = start_q.pop_front();
      check("b2b_no_gap", 32'(s2 - s1), 32'd20);
    end else begin
      check("b2b_frame_count", 32'(start_q.size()), 32'd2);
    end
    idle(3);

    // overflow at DIV=100
    wr(2'd2, 32'd100, 4'b0011);
    base = frames_done;
    for (int i = 0; i < 6; i++) push(8'($urandom_range(0, 255)), i < DEPTH + 1);
    rd_reg(2'd1, status_word(1, DEPTH, 1), "status_overflow");
    wr(2'd1, 32'h0000_0100, 4'b0001);
    rd_reg(2'd1, status_word(1, DEPTH, 1), "ovf_kept_wrong_strobe");
    wr(2'd1, 32'h0000_0100, 4'b0010);
    rd_reg(2'd1, status_word(1, DEPTH, 0), "ovf_cleared");
    wait_frames(base + DEPTH + 1, 6000);
    idle(3);
    rd_reg(2'd1, status_word(0, 0, 0), "status_after_overflow");

    // randomized bursts
    for (int it = 0; it < 5; it++) begin
      dv = $urandom_range(0, 5);
      wr(2'd2, 32'(dv), 4'b0011);
      n = $urandom_range(1, DEPTH + 1);
      start_q.delete();
      base = frames_done;
      for (int j = 0; j < n; j++) push(8'($urandom_range(0, 255)), 1'b1);
      wait_frames(base + n, n * 10 * model_div + 50);
      for (int j = 1; j < n && start_q.size() >= 2; j++) begin
        s1 = start_q.pop_front();
        check("rand_frame_spacing", 32'(start_q[0] - s1), 32'(10 * model_div));
      end
      idle(3);
      rd_reg(2'd1, status_word(0, 0, 0), "rand_status_idle");
      rd_reg(2'd2, 32'(model_div), "rand_div_readback");
    end

    // reset during DATA bit 3, with a bus write and read in the reset cycle
    wr(2'd2, 32'd4, 4'b0011);
    mon_en = 1'b0;
    wr(2'd0, 32'h07, 4'b0001);
    n = 0;
    while (tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_frame_started", {31'd0, tx}, 32'd0);
    wr(2'd0, 32'hAA, 4'b0001);
    idle(16);
    check("abort_in_bit3", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    re = 1'b1;
    a = 32'd0;
    wd = 32'h99;
    wstrb = 4'b0001;
    @(negedge clk);
    rst = 1'b0;
    re = 1'b0;
    wstrb = 4'd0;
    model_div = DIV_RST;
    model_ovf = 1'b0;
    check("tx_after_reset", {31'd0, tx}, 32'd1);
    check("rd_after_reset", rd, 32'd0);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no_bits_after_reset", 32'(lows), 32'd0);
    mon_en = 1'b1;
    rd_reg(2'd1, 32'h0000_0004, "status_after_reset");
    rd_reg(2'd2, 32'd117, "div_after_reset");

    idle(2);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
